// File: rtl/bin_bbox_overlay.sv
// Per-frame foreground bounding-box statistics on a binary pixel stream, with the
// previous frame's box overlaid as a 1-pixel rectangle on an 8-bit grey output.
module bin_bbox_overlay #(
  parameter int         IMG_W      = 1280,
  parameter int         IMG_H      = 720,
  parameter int         CW         = 11,
  parameter int         NW         = 20,
  parameter int         MIN_PIXELS = 16,
  parameter logic [7:0] BOX_COLOR  = 8'd128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pre_img_vsync,
  input  logic          pre_img_hsync,
  input  logic          pre_img_valid,
  input  logic          pre_img_data,
  output logic          post_img_vsync,
  output logic          post_img_hsync,
  output logic          post_img_valid,
  output logic [7:0]    post_img_data,
  output logic          bbox_valid,
  output logic          bbox_found,
  output logic [CW-1:0] bbox_xmin,
  output logic [CW-1:0] bbox_xmax,
  output logic [CW-1:0] bbox_ymin,
  output logic [CW-1:0] bbox_ymax,
  output logic [NW-1:0] bbox_count
);

  localparam logic [CW-1:0] X_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(IMG_H - 1);

  logic          vsync_d, valid_d;
  logic [CW-1:0] x_cnt, y_cnt;
  logic          x_ovf, y_ovf;
  logic          synced, frame_active;
  logic [CW-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [NW-1:0] acc_count;

  logic          vsync_rise, valid_fall, line_end, in_range, hit;
  logic          frame_active_nxt, found_nxt, border;
  logic [CW-1:0] nxt_xmin, nxt_xmax, nxt_ymin, nxt_ymax;
  logic [NW-1:0] nxt_count;

  assign vsync_rise = pre_img_vsync & ~vsync_d;
  assign valid_fall = valid_d & ~pre_img_valid;
  // Lines that end during vertical sync belong to no frame and must not advance y.
  assign line_end   = valid_fall & ~pre_img_vsync;
  assign in_range   = ~x_ovf & ~y_ovf;
  assign hit        = pre_img_valid & pre_img_data & in_range;

  // Only frames that began with a vsync seen since reset may publish statistics.
  assign frame_active_nxt = frame_active | (pre_img_valid & synced);

  // NOTE: every combinational output is given a default first so no path holds a
  // previous value, which would otherwise infer a latch.
  always_comb begin
    nxt_count = acc_count;
    nxt_xmin  = acc_xmin;
    nxt_xmax  = acc_xmax;
    nxt_ymin  = acc_ymin;
    nxt_ymax  = acc_ymax;
    if (hit) begin
      if (acc_count != '1) nxt_count = acc_count + 1'b1;
      if (x_cnt < acc_xmin) nxt_xmin = x_cnt;
      if (x_cnt > acc_xmax) nxt_xmax = x_cnt;
      if (y_cnt < acc_ymin) nxt_ymin = y_cnt;
      if (y_cnt > acc_ymax) nxt_ymax = y_cnt;
    end
  end

  assign found_nxt = (nxt_count >= NW'(MIN_PIXELS));

  // NOTE: sequential state uses non-blocking assignments so every register in the
  // block samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      valid_d <= 1'b0;
      x_cnt   <= '0;
      x_ovf   <= 1'b0;
      y_cnt   <= '0;
      y_ovf   <= 1'b0;
    end else begin
      vsync_d <= pre_img_vsync;
      valid_d <= pre_img_valid;
      if (pre_img_hsync || valid_fall) begin
        x_cnt <= '0;
        x_ovf <= 1'b0;
      end else if (pre_img_valid) begin
        if (x_cnt == X_LAST) x_ovf <= 1'b1;
        else                 x_cnt <= x_cnt + 1'b1;
      end
      if (vsync_rise) begin
        y_cnt <= '0;
        y_ovf <= 1'b0;
      end else if (line_end) begin
        if (y_cnt == Y_LAST) y_ovf <= 1'b1;
        else                 y_cnt <= y_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      synced       <= 1'b0;
      frame_active <= 1'b0;
      acc_count    <= '0;
      acc_xmin     <= '1;
      acc_xmax     <= '0;
      acc_ymin     <= '1;
      acc_ymax     <= '0;
      bbox_valid   <= 1'b0;
      bbox_found   <= 1'b0;
      bbox_xmin    <= '0;
      bbox_xmax    <= '0;
      bbox_ymin    <= '0;
      bbox_ymax    <= '0;
      bbox_count   <= '0;
    end else begin
      bbox_valid <= 1'b0;
      if (vsync_rise) begin
        // The pixel arriving with the vsync edge still closes into this frame.
        if (frame_active_nxt) begin
          bbox_valid <= 1'b1;
          bbox_found <= found_nxt;
          bbox_count <= nxt_count;
          bbox_xmin  <= found_nxt ? nxt_xmin : '0;
          bbox_xmax  <= found_nxt ? nxt_xmax : '0;
          bbox_ymin  <= found_nxt ? nxt_ymin : '0;
          bbox_ymax  <= found_nxt ? nxt_ymax : '0;
        end
        synced       <= 1'b1;
        frame_active <= 1'b0;
        acc_count    <= '0;
        acc_xmin     <= '1;
        acc_xmax     <= '0;
        acc_ymin     <= '1;
        acc_ymax     <= '0;
      end else begin
        frame_active <= frame_active_nxt;
        acc_count    <= nxt_count;
        acc_xmin     <= nxt_xmin;
        acc_xmax     <= nxt_xmax;
        acc_ymin     <= nxt_ymin;
        acc_ymax     <= nxt_ymax;
      end
    end
  end

  // Out-of-image pixels at saturated coordinates never land on the box edge.
  assign border = bbox_found & in_range &
                  ((((x_cnt == bbox_xmin) || (x_cnt == bbox_xmax)) &&
                    (y_cnt >= bbox_ymin) && (y_cnt <= bbox_ymax)) ||
                   (((y_cnt == bbox_ymin) || (y_cnt == bbox_ymax)) &&
                    (x_cnt >= bbox_xmin) && (x_cnt <= bbox_xmax)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_img_vsync <= 1'b0;
      post_img_hsync <= 1'b0;
      post_img_valid <= 1'b0;
      post_img_data  <= 8'd0;
    end else begin
      post_img_vsync <= pre_img_vsync;
      post_img_hsync <= pre_img_hsync;
      post_img_valid <= pre_img_valid;
      if (!pre_img_valid) post_img_data <= 8'd0;
      else if (border)    post_img_data <= BOX_COLOR;
      else                post_img_data <= pre_img_data ? 8'hFF : 8'h00;
    end
  end

endmodule

// File: tb/tb_bin_bbox_overlay.sv
// Scoreboard bench for bin_bbox_overlay: two instances (MIN_PIXELS 1 and 16) share one
// directed stream; expected boxes are hand-computed, expected video derives from them.
module tb_bin_bbox_overlay;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int CW = 11;
  localparam int NW = 20;

  typedef struct packed {
    logic          found;
    logic [CW-1:0] xmin;
    logic [CW-1:0] xmax;
    logic [CW-1:0] ymin;
    logic [CW-1:0] ymax;
    logic [NW-1:0] count;
  } box_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } vid_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pre_vsync = 1'b0, pre_hsync = 1'b0, pre_valid = 1'b0, pre_data = 1'b0;

  logic [1:0]          o_vs, o_hs, o_val, bv, bf;
  logic [1:0][7:0]     o_data;
  logic [1:0][CW-1:0]  xmin, xmax, ymin, ymax;
  logic [1:0][NW-1:0]  cnt;

  box_t qbox[2][$];
  vid_t qvid[2][$];
  box_t cur[2];
  bit   bv_prev[2];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  bin_bbox_overlay #(.IMG_W(W), .IMG_H(H), .CW(CW), .NW(NW), .MIN_PIXELS(1), .BOX_COLOR(8'd128)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .pre_img_vsync(pre_vsync), .pre_img_hsync(pre_hsync), .pre_img_valid(pre_valid), .pre_img_data(pre_data),
    .post_img_vsync(o_vs[0]), .post_img_hsync(o_hs[0]), .post_img_valid(o_val[0]), .post_img_data(o_data[0]),
    .bbox_valid(bv[0]), .bbox_found(bf[0]), .bbox_xmin(xmin[0]), .bbox_xmax(xmax[0]),
    .bbox_ymin(ymin[0]), .bbox_ymax(ymax[0]), .bbox_count(cnt[0]));

  bin_bbox_overlay #(.IMG_W(W), .IMG_H(H), .CW(CW), .NW(NW), .MIN_PIXELS(16), .BOX_COLOR(8'd128)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .pre_img_vsync(pre_vsync), .pre_img_hsync(pre_hsync), .pre_img_valid(pre_valid), .pre_img_data(pre_data),
    .post_img_vsync(o_vs[1]), .post_img_hsync(o_hs[1]), .post_img_valid(o_val[1]), .post_img_data(o_data[1]),
    .bbox_valid(bv[1]), .bbox_found(bf[1]), .bbox_xmin(xmin[1]), .bbox_xmax(xmax[1]),
    .bbox_ymin(ymin[1]), .bbox_ymax(ymax[1]), .bbox_count(cnt[1]));

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic box_t mk(input bit f, input int x0, input int x1, input int y0, input int y1, input int c);
    box_t b;
    b.found = f;
    b.xmin  = CW'(x0);
    b.xmax  = CW'(x1);
    b.ymin  = CW'(y0);
    b.ymax  = CW'(y1);
    b.count = NW'(c);
    return b;
  endfunction

  // Foreground patterns: 1 single pixel, 2 rectangle, 3 ten-pixel row, 4 over-long line.
  function automatic bit fg(input int pat, input int x, input int y);
    case (pat)
      1:       return (x == 5) && (y == 3);
      2:       return (x >= 2) && (x <= 9) && (y >= 1) && (y <= 4);
      3:       return (y == 2) && (x >= 3) && (x <= 12);
      4:       return (y == 2) && ((x == 4) || (x == 18));
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] exp_pix(input box_t b, input int x, input int y, input bit d);
    bit on_v, on_h;
    on_v = ((x == int'(b.xmin)) || (x == int'(b.xmax))) && (y >= int'(b.ymin)) && (y <= int'(b.ymax));
    on_h = ((y == int'(b.ymin)) || (y == int'(b.ymax))) && (x >= int'(b.xmin)) && (x <= int'(b.xmax));
    if (b.found && (x < W) && (y < H) && (on_v || on_h)) return 8'd128;
    return d ? 8'd255 : 8'd0;
  endfunction

  task automatic drive(input bit vs, input bit hs, input bit v, input bit d, input int x, input int y);
    @(negedge clk);
    pre_vsync = vs;
    pre_hsync = hs;
    pre_valid = v;
    pre_data  = d;
    if (v) for (int k = 0; k < 2; k++) qvid[k].push_back('{exp_pix(cur[k], x, y, d), cyc + 1});
  endtask

  task automatic line(input int pat, input int y, input int w);
    drive(0, 1, 0, 0, 0, y);
    drive(0, 0, 0, 0, 0, y);
    for (int x = 0; x < w; x++) drive(0, 0, 1, fg(pat, x, y), x, y);
    drive(0, 0, 0, 0, 0, y);
    drive(0, 0, 0, 0, 0, y);
  endtask

  task automatic frame(input int pat, input int nlines);
    for (int y = 0; y < nlines; y++) line(pat, y, ((pat == 4) && (y == 2)) ? 20 : W);
  endtask

  // Vsync rise closes the previous frame; optional foreground pixel on the edge cycle.
  task automatic close_frame(input bit coinc, input int cx, input int cy, input bit has_exp,
                             input box_t ea, input box_t eb);
    drive(1, 0, coinc, coinc, cx, cy);
    if (has_exp) begin
      qbox[0].push_back(ea);
      qbox[1].push_back(eb);
      cur[0] = ea;
      cur[1] = eb;
    end
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++)
      check($sformatf("%s[%0d]", tag, d),
            {o_vs[d], o_hs[d], o_val[d], o_data[d], bv[d], bf[d], xmin[d], xmax[d], ymin[d], ymax[d], cnt[d]}, '0);
  endtask

  // Monitor: pops expected video/box entries whenever the DUT presents them.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst_n) begin
      bv_prev[0] = 1'b0;
      bv_prev[1] = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("sync_delay[%0d]", d), {o_vs[d], o_hs[d], o_val[d]}, {pre_vsync, pre_hsync, pre_valid});
        if (o_val[d]) begin
          if (qvid[d].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL vid_extra[%0d]: got unexpected pixel 0x%0h, expected none", d, o_data[d]);
          end else begin
            vid_t e;
            e = qvid[d].pop_front();
            check($sformatf("vid[%0d]", d), o_data[d], e.data);
            check($sformatf("vid_latency[%0d]", d), cyc, e.cyc);
          end
        end
        if (bv[d]) begin
          check($sformatf("bbox_pulse_width[%0d]", d), bv_prev[d], 1'b0);
          if (qbox[d].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL bbox_extra[%0d]: got unexpected bbox_valid pulse, expected none", d);
          end else begin
            box_t e;
            e = qbox[d].pop_front();
            check($sformatf("bbox[%0d]", d), {bf[d], xmin[d], xmax[d], ymin[d], ymax[d], cnt[d]}, e);
          end
        end
        bv_prev[d] = bv[d];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cur[0] = '0;
    cur[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    // First vsync after reset: nothing to publish.
    close_frame(0, 0, 0, 0, '0, '0);

    frame(1, H);
    close_frame(0, 0, 0, 1, mk(1, 5, 5, 3, 3, 1), mk(0, 0, 0, 0, 0, 1));

    frame(2, H);
    close_frame(0, 0, 0, 1, mk(1, 2, 9, 1, 4, 32), mk(1, 2, 9, 1, 4, 32));

    // Empty frame shows the rectangle border; closes with zero count.
    frame(0, H);
    close_frame(0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0));

    frame(3, H);
    close_frame(0, 0, 0, 1, mk(1, 3, 12, 2, 2, 10), mk(0, 0, 0, 0, 0, 10));

    // Short frame; foreground pixel on the vsync edge lands at (0,4) of the closing frame.
    frame(1, 4);
    close_frame(1, 0, 4, 1, mk(1, 0, 5, 3, 4, 2), mk(0, 0, 0, 0, 0, 2));

    // Line 2 carries 20 pixels; foreground at 18 is beyond the image.
    frame(4, H);
    close_frame(0, 0, 0, 1, mk(1, 4, 4, 2, 2, 1), mk(0, 0, 0, 0, 0, 1));

    // Asynchronous reset between clock edges in the middle of a frame.
    line(2, 0, W);
    line(2, 1, W);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    cur[0] = '0;
    cur[1] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int y = 2; y < H; y++) line(2, y, W);
    close_frame(0, 0, 0, 0, '0, '0);

    frame(2, H);
    close_frame(0, 0, 0, 1, mk(1, 2, 9, 1, 4, 32), mk(1, 2, 9, 1, 4, 32));

    frame(0, H);
    close_frame(0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0));

    repeat (4) drive(0, 0, 0, 0, 0, 0);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("bbox_pending[%0d]", d), qbox[d].size(), 0);
      check($sformatf("vid_pending[%0d]", d), qvid[d].size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
